// File: rtl/rr_onehot_scheduler_pkg.sv
// Shared constants and types for the round-robin one-hot scheduler.
// The FSM encoding is kept as plain localparams so legacy code can compare against it.
package rr_onehot_scheduler_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [ID_W-1:0]  id_t;

endpackage

// File: rtl/rr_onehot_scheduler_if.sv
// Requester-side bus of the scheduler: request/done in, one-hot grant and status out.
interface rr_onehot_scheduler_if;
   import rr_onehot_scheduler_pkg::*;

   req_vec_t req;
   logic     done;
   req_vec_t gnt;
   id_t      gnt_id;
   logic     gnt_valid;
   logic     timeout_err;

   modport master (
      output req, done,
      input  gnt, gnt_id, gnt_valid, timeout_err
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, gnt_valid, timeout_err
   );

endinterface

// File: rtl/rr_onehot_scheduler_onehot_dec3.sv
// 3-bit index to 8-bit one-hot decoder with enable; output is all-zero when disabled.
module onehot_dec3
   import rr_onehot_scheduler_pkg::*;
(
   input  id_t      i_idx,
   input  logic     i_en,
   output req_vec_t o_onehot
);

   // decode the index into a single set bit when enabled
   always_comb begin
      o_onehot = 8'h00;
      if (i_en) begin
         o_onehot[i_idx] = 1'b1;
      end else begin
         o_onehot = 8'h00;
      end
   end

endmodule

// File: rtl/rr_onehot_scheduler.sv
// Round-robin scheduler for 8 requesters: holds a grant until done, withdraw or
// MAX_HOLD cycles, then returns to IDLE for one cycle and rotates priority.
module rr_onehot_scheduler
   import rr_onehot_scheduler_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   rr_onehot_scheduler_if.slave   bus
);

   logic             r_state;
   id_t              r_gnt_id;
   id_t              r_last_id;
   logic [CNT_W-1:0] r_hold_cnt;
   logic             r_timeout_err;

   id_t              w_pick;
   logic             w_normal_rel;
   logic             w_timeout;
   logic             w_grant_active;
   req_vec_t         w_gnt;

   // Rotate so the requester after last_id sits at bit 0, take the lowest set
   // bit, then add the rotation back (3-bit wrap does the modulo).
   function automatic id_t rr_pick(input req_vec_t req, input id_t last);
      id_t      start;
      req_vec_t rot;
      id_t      k;
      start = last + 3'd1;
      rot   = (req >> start) | (req << (N_REQ - int'(start)));
      k     = 3'd0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k = id_t'(i);
         end else begin
            k = k;
         end
      end
      return k + start;
   endfunction

   // next-winner selection and release conditions
   always_comb begin
      w_pick         = rr_pick(bus.req, r_last_id);
      w_normal_rel   = 1'b0;
      w_timeout      = 1'b0;
      w_grant_active = (r_state == ST_GRANT);
      if (w_grant_active) begin
         w_normal_rel = bus.done | ~bus.req[r_gnt_id];
         w_timeout    = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
      end else begin
         w_normal_rel = 1'b0;
         w_timeout    = 1'b0;
      end
   end

   // scheduler FSM, hold counter and timeout pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_gnt_id      <= 3'd0;
         r_last_id     <= 3'd7;
         r_hold_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_timeout_err <= 1'b0;
               r_hold_cnt    <= '0;
               if (|bus.req) begin
                  r_gnt_id <= w_pick;
                  r_state  <= ST_GRANT;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (w_normal_rel || w_timeout) begin
                  r_state       <= ST_IDLE;
                  r_last_id     <= r_gnt_id;
                  r_hold_cnt    <= '0;
                  // a normal release on the timeout cycle wins: no error
                  r_timeout_err <= w_timeout & ~w_normal_rel;
               end else begin
                  r_hold_cnt    <= r_hold_cnt + CNT_W'(1);
                  r_timeout_err <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_hold_cnt    <= '0;
               r_timeout_err <= 1'b0;
            end
         endcase
      end
   end

   onehot_dec3 u_dec (
      .i_idx    (r_gnt_id),
      .i_en     (w_grant_active),
      .o_onehot (w_gnt)
   );

   assign bus.gnt         = w_gnt;
   assign bus.gnt_id      = r_gnt_id;
   assign bus.gnt_valid   = w_grant_active;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rr_onehot_scheduler.sv
// Scoreboard bench: a queue/integer reference model predicts every cycle's
// outputs, a negedge monitor pops and compares.
module tb_rr_onehot_scheduler;

   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rr_onehot_scheduler_if bus ();

   rr_onehot_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] id;
      logic       v;
      logic       to;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // reference model: owner index, last owner, cycles granted so far
   bit m_grant = 1'b0;
   int m_owner = 0;
   int m_last  = 7;
   int m_len   = 0;
   bit m_to    = 1'b0;

   task automatic model_update(input logic [7:0] r, input logic d, input logic rs);
      bit rel_norm;
      bit rel_to;
      if (rs) begin
         m_grant = 1'b0; m_owner = 0; m_last = 7; m_len = 0; m_to = 1'b0;
      end else if (!m_grant) begin
         m_to = 1'b0;
         if (r != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               if (r[(m_last + k) % 8] && !m_grant) begin
                  m_owner = (m_last + k) % 8;
                  m_grant = 1'b1;
                  m_len   = 1;
               end
            end
         end
      end else begin
         rel_norm = d || !r[m_owner];
         rel_to   = (m_len == MAX_HOLD);
         if (rel_norm || rel_to) begin
            m_grant = 1'b0;
            m_last  = m_owner;
            m_to    = rel_to && !rel_norm;
         end else begin
            m_len = m_len + 1;
            m_to  = 1'b0;
         end
      end
   endtask

   task automatic step(input logic [7:0] r, input logic d, input logic rs);
      exp_t e;
      bus.req = r;
      bus.done = d;
      reset = rs;
      model_update(r, d, rs);
      e.gnt = m_grant ? 8'(1 << m_owner) : 8'h00;
      e.id  = 3'(m_owner);
      e.v   = m_grant;
      e.to  = m_to;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // run n cycles with a fixed request; done pulses on grant cycle done_len
   task automatic run(input logic [7:0] r, input logic [31:0] done_len, input int n);
      for (int i = 0; i < n; i++) begin
         step(r, m_grant && (m_len == done_len), 1'b0);
      end
   endtask

   // directed check of the current DUT outputs
   task automatic check_now(input logic cond, input string what);
      total++;
      if (cond !== 1'b1) begin
         bad++;
         $display("FAIL %s: gnt=%h id=%0d valid=%b to=%b",
                  what, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout_err);
      end
   endtask

   // monitor: compare DUT outputs against the oldest prediction
   always @(negedge clk) begin : monitor
      exp_t e;
      exp_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout_err};
         total++;
         cyc++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle%0d: got gnt=%h id=%0d valid=%b to=%b, want gnt=%h id=%0d valid=%b to=%b",
                     cyc, a.gnt, a.id, a.v, a.to, e.gnt, e.id, e.v, e.to);
         end
      end
   end

   initial begin
      logic [7:0] r;
      logic       d;
      logic       rs;
      bit         dropped;
      bus.req = 8'h00; bus.done = 1'b0; reset = 1'b1;
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      check_now((bus.gnt == 8'h00) && (bus.gnt_valid == 1'b0) &&
                (bus.gnt_id == 3'd0) && (bus.timeout_err == 1'b0), "reset state");
      // 1: id 0 first, then id 7 after one idle cycle
      run(8'h81, 32'd1, 6);
      // 2: full rotation with done on every grant's 2nd cycle
      run(8'hFF, 32'd2, 30);
      // 3: single requester, never done: timeout and re-grant
      step(8'h00, 1'b0, 1'b1);
      run(8'h04, 32'd99, 16);
      check_now((bus.gnt == 8'h04) && (bus.gnt_valid == 1'b1) &&
                (bus.gnt_id == 3'd2) && (bus.timeout_err == 1'b0), "16th grant cycle");
      run(8'h04, 32'd99, 1);
      check_now((bus.timeout_err == 1'b1) && (bus.gnt == 8'h00) &&
                (bus.gnt_valid == 1'b0), "expired wait");
      run(8'h04, 32'd99, 23);
      // 4: done on the timeout cycle
      run(8'h04, 32'(MAX_HOLD), 40);
      run(8'h00, 32'd99, 2);
      // 5: owner withdraws on its 3rd cycle
      dropped = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (m_grant && m_owner == 3 && m_len == 3) dropped = 1'b1;
         step(dropped ? 8'h04 : 8'h0C, 1'b0, 1'b0);
      end
      // 6: reset in the middle of a grant
      run(8'h30, 32'd99, 4);
      step(8'h30, 1'b0, 1'b1);
      run(8'h30, 32'd3, 6);
      // random traffic with rare resets
      r = 8'h00;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) r = r ^ 8'(1 << $urandom_range(0, 7));
         if ($urandom_range(0, 40) == 0) r = 8'($urandom);
         d  = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 150) == 0);
         step(r, d, rs);
      end
      step(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
